// File: rtl/alu_operand_issue_if.sv
// Decode-to-ALU issue bus for alu_operand_issue: operand sources, forwarding taps,
// flush and both valid/ready handshakes. The slave modport is the issue block's view.
interface alu_operand_issue_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [REG_ADDR_W-1:0] rs1_addr_i;
    logic [REG_ADDR_W-1:0] rs2_addr_i;
    logic [XLEN-1:0]       rs1_data_i;
    logic [XLEN-1:0]       rs2_data_i;
    logic [XLEN-1:0]       pc_i;
    logic [XLEN-1:0]       imm_i;
    logic [1:0]            a_sel_i;
    logic [1:0]            b_sel_i;
    logic [4:0]            alu_op_i;
    logic                  fwd_ex_we_i;
    logic                  fwd_wb_we_i;
    logic [REG_ADDR_W-1:0] fwd_ex_addr_i;
    logic [REG_ADDR_W-1:0] fwd_wb_addr_i;
    logic [XLEN-1:0]       fwd_ex_data_i;
    logic [XLEN-1:0]       fwd_wb_data_i;
    logic                  flush_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [XLEN-1:0]       alu_a_o;
    logic [XLEN-1:0]       alu_b_o;
    logic [4:0]            alu_op_o;

    modport master (
        output in_valid_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               a_sel_i, b_sel_i, alu_op_i, fwd_ex_we_i, fwd_wb_we_i, fwd_ex_addr_i,
               fwd_wb_addr_i, fwd_ex_data_i, fwd_wb_data_i, flush_i, out_ready_i,
        input  in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o
    );

    modport slave (
        input  in_valid_i, rs1_addr_i, rs2_addr_i, rs1_data_i, rs2_data_i, pc_i, imm_i,
               a_sel_i, b_sel_i, alu_op_i, fwd_ex_we_i, fwd_wb_we_i, fwd_ex_addr_i,
               fwd_wb_addr_i, fwd_ex_data_i, fwd_wb_data_i, flush_i, out_ready_i,
        output in_ready_o, out_valid_o, alu_a_o, alu_b_o, alu_op_o
    );
endinterface

// File: rtl/alu_operand_issue.sv
// Execute-stage operand select with EX/WB forwarding and a 2-entry skid buffer feeding the ALU.
// Optional ALU_OP_CHECK_EN: illegal op codes are dropped and flagged on sticky illegal_op_o.
module alu_operand_issue #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    alu_operand_issue_if.slave io
`ifdef ALU_OP_CHECK_EN
    ,
    output logic               illegal_op_o
`endif
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_e;

    state_e                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic                  in_ready_q, in_ready_d;
    logic [XLEN-1:0]       main_a_q, main_a_d, main_b_q, main_b_d;
    logic [XLEN-1:0]       skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [4:0]            main_op_q, main_op_d, skid_op_q, skid_op_d;
    logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
    logic [XLEN-1:0]       rs1_fwd, rs2_fwd, new_a, new_b;
    logic                  op_legal, accept, store, take;

    assign rs1_addr = io.rs1_addr_i;
    assign rs2_addr = io.rs2_addr_i;

    // EX holds the younger result, so it wins over WB; x0 always reads the register file.
    always_comb begin
        rs1_fwd = io.rs1_data_i;
        if (rs1_addr != '0) begin
            if (io.fwd_ex_we_i && io.fwd_ex_addr_i == rs1_addr)      rs1_fwd = io.fwd_ex_data_i;
            else if (io.fwd_wb_we_i && io.fwd_wb_addr_i == rs1_addr) rs1_fwd = io.fwd_wb_data_i;
        end
        rs2_fwd = io.rs2_data_i;
        if (rs2_addr != '0) begin
            if (io.fwd_ex_we_i && io.fwd_ex_addr_i == rs2_addr)      rs2_fwd = io.fwd_ex_data_i;
            else if (io.fwd_wb_we_i && io.fwd_wb_addr_i == rs2_addr) rs2_fwd = io.fwd_wb_data_i;
        end
        case (io.a_sel_i)
            2'd0:    new_a = rs1_fwd;
            2'd1:    new_a = io.pc_i;
            default: new_a = '0;
        endcase
        case (io.b_sel_i)
            2'd0:    new_b = rs2_fwd;
            2'd1:    new_b = io.imm_i;
            2'd2:    new_b = XLEN'(4);
            default: new_b = '0;
        endcase
    end

`ifdef ALU_OP_CHECK_EN
    logic illegal_q, illegal_d;

    always_comb begin
        case (io.alu_op_i)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8,
            5'd13, 5'd24, 5'd25, 5'd28, 5'd29, 5'd30, 5'd31: op_legal = 1'b1;
            default:                                         op_legal = 1'b0;
        endcase
    end
`else
    assign op_legal = 1'b1;
`endif

    assign accept = io.in_valid_i && in_ready_q;
    assign store  = accept && op_legal;
    assign take   = out_valid_q && io.out_ready_i;

    always_comb begin
        state_d   = state_q;
        main_a_d  = main_a_q;
        main_b_d  = main_b_q;
        main_op_d = main_op_q;
        skid_a_d  = skid_a_q;
        skid_b_d  = skid_b_q;
        skid_op_d = skid_op_q;
        if (io.flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (store) begin
                    main_a_d = new_a; main_b_d = new_b; main_op_d = io.alu_op_i;
                    state_d  = S_ONE;
                end
                S_ONE: begin
                    if (store && !take) begin
                        skid_a_d = new_a; skid_b_d = new_b; skid_op_d = io.alu_op_i;
                        state_d  = S_TWO;
                    end else if (store && take) begin
                        main_a_d = new_a; main_b_d = new_b; main_op_d = io.alu_op_i;
                    end else if (take) begin
                        state_d = S_EMPTY;
                    end
                end
                S_TWO: if (take) begin
                    main_a_d = skid_a_q; main_b_d = skid_b_q; main_op_d = skid_op_q;
                    state_d  = S_ONE;
                end
                default: state_d = S_EMPTY;
            endcase
        end
        out_valid_d = (state_d != S_EMPTY);
        in_ready_d  = (state_d != S_TWO);
    end

`ifdef ALU_OP_CHECK_EN
    assign illegal_d = illegal_q | (accept && !op_legal && !io.flush_i);
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_EMPTY;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            main_a_q    <= '0;
            main_b_q    <= '0;
            main_op_q   <= '0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_op_q   <= '0;
`ifdef ALU_OP_CHECK_EN
            illegal_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            main_a_q    <= main_a_d;
            main_b_q    <= main_b_d;
            main_op_q   <= main_op_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
            skid_op_q   <= skid_op_d;
`ifdef ALU_OP_CHECK_EN
            illegal_q   <= illegal_d;
`endif
        end
    end

    assign io.in_ready_o  = in_ready_q;
    assign io.out_valid_o = out_valid_q;
    assign io.alu_a_o     = main_a_q;
    assign io.alu_b_o     = main_b_q;
    assign io.alu_op_o    = main_op_q;
`ifdef ALU_OP_CHECK_EN
    assign illegal_op_o   = illegal_q;
`endif
endmodule

// File: tb/tb_alu_operand_issue.sv
// Scoreboard bench for alu_operand_issue: directed cases, then random traffic with
// forwarding hazards, backpressure and flushes checked against a queue-based model.
module tb_alu_operand_issue;
    localparam int XLEN = 32;
    localparam int RW   = 5;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      op;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_operand_issue_if #(.XLEN(XLEN), .REG_ADDR_W(RW)) bus ();
`ifdef ALU_OP_CHECK_EN
    logic illegal_op;
`endif

    alu_operand_issue #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .io           (bus.slave)
`ifdef ALU_OP_CHECK_EN
        ,
        .illegal_op_o (illegal_op)
`endif
    );

    exp_t sb[$];
    int   tests = 0;
    int   errors = 0;
    int   n_out = 0;
    bit   occ_chk_en = 1'b0;
    bit   held_v = 1'b0;
    exp_t held;
    exp_t popped;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: the newest in-flight writer of a register supplies its value.
    function automatic logic [XLEN-1:0] reg_value(input logic [RW-1:0] addr, input logic [XLEN-1:0] rf);
        logic [XLEN-1:0] v = rf;
        if (addr == 0) return rf;
        if (bus.fwd_wb_we_i && bus.fwd_wb_addr_i == addr) v = bus.fwd_wb_data_i;
        if (bus.fwd_ex_we_i && bus.fwd_ex_addr_i == addr) v = bus.fwd_ex_data_i;
        return v;
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [XLEN-1:0] b_choices [4];
        b_choices[0] = reg_value(bus.rs2_addr_i, bus.rs2_data_i);
        b_choices[1] = bus.imm_i;
        b_choices[2] = 32'd4;
        b_choices[3] = 32'd0;
        e.a  = (bus.a_sel_i == 2'd0) ? reg_value(bus.rs1_addr_i, bus.rs1_data_i) :
               (bus.a_sel_i == 2'd1) ? bus.pc_i : 32'd0;
        e.b  = b_choices[bus.b_sel_i];
        e.op = bus.alu_op_i;
        return e;
    endfunction

    function automatic bit legal(input logic [4:0] op);
`ifdef ALU_OP_CHECK_EN
        return (op <= 5'd8) || op == 5'd13 || op == 5'd24 || op == 5'd25 || op >= 5'd28;
`else
        return 1'b1;
`endif
    endfunction

    // Stimulus side: record each accepted operation.
    always @(negedge clk) begin
        if (rst_n && !bus.flush_i && bus.in_valid_i && bus.in_ready_o && legal(bus.alu_op_i))
            sb.push_back(model());
    end

    // Monitor side: pop and compare on every output transfer; check hold stability.
    always @(negedge clk) begin
        if (!rst_n || bus.flush_i) begin
            sb.delete();
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("hold_valid", {31'b0, bus.out_valid_o}, 32'd1);
                check("hold_a", bus.alu_a_o, held.a);
                check("hold_b", bus.alu_b_o, held.b);
                check("hold_op", {27'b0, bus.alu_op_o}, {27'b0, held.op});
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                n_out++;
                if (sb.size() == 0) begin
                    check("spurious_output", 32'd1, 32'd0);
                end else begin
                    popped = sb.pop_front();
                    check("out_a", bus.alu_a_o, popped.a);
                    check("out_b", bus.alu_b_o, popped.b);
                    check("out_op", {27'b0, bus.alu_op_o}, {27'b0, popped.op});
                end
            end
            held_v = bus.out_valid_o && !bus.out_ready_i;
            held   = '{a: bus.alu_a_o, b: bus.alu_b_o, op: bus.alu_op_o};
        end
    end

    always @(posedge clk) begin
        #2;
        if (occ_chk_en && rst_n)
            check("in_ready_occupancy", {31'b0, bus.in_ready_o}, {31'b0, sb.size() < 2});
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.in_valid_i = 0; bus.flush_i = 0; bus.out_ready_i = 1;
        bus.rs1_addr_i = 5'd1; bus.rs2_addr_i = 5'd2;
        bus.rs1_data_i = 0; bus.rs2_data_i = 0; bus.pc_i = 0; bus.imm_i = 0;
        bus.a_sel_i = 0; bus.b_sel_i = 0; bus.alu_op_i = 0;
        bus.fwd_ex_we_i = 0; bus.fwd_wb_we_i = 0;
        bus.fwd_ex_addr_i = 0; bus.fwd_wb_addr_i = 0;
        bus.fwd_ex_data_i = 0; bus.fwd_wb_data_i = 0;
    endtask

    task automatic set_op(input logic [31:0] r1, input logic [31:0] r2, input logic [4:0] op);
        bus.rs1_data_i = r1; bus.rs2_data_i = r2; bus.alu_op_i = op;
        bus.a_sel_i = 0; bus.b_sel_i = 0;
    endtask

    task automatic send_and_check(input string name, input logic [31:0] ea, input logic [31:0] eb);
        bus.in_valid_i = 1;
        step();
        bus.in_valid_i = 0;
        @(negedge clk);
        check({name, "_valid"}, {31'b0, bus.out_valid_o}, 32'd1);
        check({name, "_a"}, bus.alu_a_o, ea);
        check({name, "_b"}, bus.alu_b_o, eb);
        step();
    endtask

    task automatic fill_two();
        bus.out_ready_i = 0;
        set_op(32'hA0, 32'hB0, 5'd4); bus.in_valid_i = 1; step();
        set_op(32'hA1, 32'hB1, 5'd5); step();
        bus.in_valid_i = 0;
    endtask

    initial begin
        int base;
        bit accepted;
        set_idle();
        #3;
        check("reset_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("reset_a", bus.alu_a_o, 32'd0);
        check("reset_op", {27'b0, bus.alu_op_o}, 32'd0);
        step(); step();
        rst_n = 1;
        step();
        check("ready_after_reset", {31'b0, bus.in_ready_o}, 32'd1);
        occ_chk_en = 1;

        // basic latency: visible next cycle, gone the cycle after
        set_op(32'd5, 32'd3, 5'd8);
        bus.in_valid_i = 1;
        step();
        bus.in_valid_i = 0;
        @(negedge clk);
        check("basic_valid", {31'b0, bus.out_valid_o}, 32'd1);
        check("basic_a", bus.alu_a_o, 32'd5);
        check("basic_b", bus.alu_b_o, 32'd3);
        check("basic_op", {27'b0, bus.alu_op_o}, 32'd8);
        step();
        @(negedge clk);
        check("basic_drained", {31'b0, bus.out_valid_o}, 32'd0);
        step();

        // forwarding priority and x0
        set_op(32'h33, 32'h44, 5'd0);
        bus.rs1_addr_i = 5'd7; bus.rs2_addr_i = 5'd9;
        bus.fwd_ex_we_i = 1; bus.fwd_ex_addr_i = 5'd7; bus.fwd_ex_data_i = 32'h11;
        bus.fwd_wb_we_i = 1; bus.fwd_wb_addr_i = 5'd7; bus.fwd_wb_data_i = 32'h22;
        send_and_check("fwd_ex", 32'h11, 32'h44);
        bus.fwd_ex_we_i = 0;
        send_and_check("fwd_wb", 32'h22, 32'h44);
        bus.rs2_addr_i = 5'd0; bus.fwd_ex_we_i = 1; bus.fwd_ex_addr_i = 0; bus.fwd_wb_addr_i = 0;
        send_and_check("fwd_x0", 32'h33, 32'h44);
        set_idle();
        bus.a_sel_i = 2'd1; bus.b_sel_i = 2'd2; bus.pc_i = 32'h8000_0010;
        send_and_check("pc_const4", 32'h8000_0010, 32'd4);
        set_idle();

        // backpressure: X, Y held, Z waits in decode
        bus.out_ready_i = 0;
        set_op(32'h100, 32'h200, 5'd1); bus.in_valid_i = 1; step();
        set_op(32'h101, 32'h201, 5'd2); step();
        set_op(32'h102, 32'h202, 5'd3); step();
        @(negedge clk);
        check("bp_in_ready", {31'b0, bus.in_ready_o}, 32'd0);
        check("bp_head_op", {27'b0, bus.alu_op_o}, 32'd1);
        base = n_out;
        step();
        bus.out_ready_i = 1;
        accepted = 0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            @(negedge clk);
            if (bus.in_ready_o) accepted = 1;
            step();
        end
        bus.in_valid_i = 0;
        check("bp_z_accepted", {31'b0, accepted}, 32'd1);
        repeat (5) step();
        check("bp_count", n_out - base, 32'd3);
        check("bp_drained", sb.size(), 32'd0);

        // flush with two held and one offered
        fill_two();
        set_op(32'hEE, 32'hFF, 5'd6);
        bus.in_valid_i = 1; bus.flush_i = 1;
        step();
        bus.in_valid_i = 0; bus.flush_i = 0;
        base = n_out;
        @(negedge clk);
        check("flush_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("flush_ready", {31'b0, bus.in_ready_o}, 32'd1);
        step();
        bus.out_ready_i = 1;
        repeat (4) step();
        check("flush_no_output", n_out - base, 32'd0);

        // asynchronous reset with two held
        fill_two();
        step();
        occ_chk_en = 0;
        #2 rst_n = 0;
        #1;
        check("midreset_valid", {31'b0, bus.out_valid_o}, 32'd0);
        check("midreset_a", bus.alu_a_o, 32'd0);
        check("midreset_b", bus.alu_b_o, 32'd0);
        check("midreset_op", {27'b0, bus.alu_op_o}, 32'd0);
        step(); step();
        rst_n = 1;
        bus.out_ready_i = 1;
        step();
        check("midreset_ready", {31'b0, bus.in_ready_o}, 32'd1);
        occ_chk_en = 1;

`ifdef ALU_OP_CHECK_EN
        check("illegal_idle", {31'b0, illegal_op}, 32'd0);
        set_op(32'h9, 32'h9, 5'd9);
        bus.in_valid_i = 1;
        step();
        bus.in_valid_i = 0;
        @(negedge clk);
        check("illegal_not_emitted", {31'b0, bus.out_valid_o}, 32'd0);
        check("illegal_flag", {31'b0, illegal_op}, 32'd1);
        repeat (3) step();
        check("illegal_sticky", {31'b0, illegal_op}, 32'd1);
        set_op(32'h7, 32'h8, 5'd0);
        send_and_check("after_illegal", 32'h7, 32'h8);
`endif

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            bus.in_valid_i    = ($urandom_range(0, 9) < 7);
            bus.out_ready_i   = ($urandom_range(0, 9) < 6);
            bus.flush_i       = ($urandom_range(0, 99) < 3);
            bus.rs1_addr_i    = 5'($urandom_range(0, 3));
            bus.rs2_addr_i    = 5'($urandom_range(0, 3));
            bus.fwd_ex_addr_i = 5'($urandom_range(0, 3));
            bus.fwd_wb_addr_i = 5'($urandom_range(0, 3));
            bus.fwd_ex_we_i   = 1'($urandom);
            bus.fwd_wb_we_i   = 1'($urandom);
            bus.rs1_data_i    = $urandom; bus.rs2_data_i    = $urandom;
            bus.fwd_ex_data_i = $urandom; bus.fwd_wb_data_i = $urandom;
            bus.pc_i          = $urandom; bus.imm_i         = $urandom;
            bus.a_sel_i       = 2'($urandom); bus.b_sel_i   = 2'($urandom);
            bus.alu_op_i      = 5'($urandom);
            step();
        end
        set_idle();
        repeat (6) step();
        check("final_drained", sb.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/alu_operand_issue.md
Name: alu_operand_issue

Overview:
- Execute-stage issue block sitting directly upstream of the RISC-V ALU; drives its A, B and ALUOp inputs.
- Selects operands (register/PC/immediate/constant) and resolves data hazards by forwarding from the two later stages.
- Registers the selected operation behind a valid/ready handshake with a 2-entry skid buffer, so decode stalls and ALU-side backpressure do not lose or duplicate operations.

Parameters:
- XLEN, 32, datapath width; ALU operand width; the ALU contract is 32.
- REG_ADDR_W, 5, register address width.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- in_valid_i  input  1  decode presents an operation.
- in_ready_o  output  1  block can accept; transfer when in_valid_i && in_ready_o.
- rs1_addr_i, rs2_addr_i  input  REG_ADDR_W  source register addresses.
- rs1_data_i, rs2_data_i  input  XLEN  register-file read data.
- pc_i  input  XLEN  instruction PC.
- imm_i  input  XLEN  sign-extended immediate.
- a_sel_i  input  2  A source: 0 rs1, 1 pc, 2 zero, 3 zero.
- b_sel_i  input  2  B source: 0 rs2, 1 imm, 2 constant 4, 3 zero.
- alu_op_i  input  5  ALU operation code, passed through unchanged.
- fwd_ex_we_i, fwd_wb_we_i  input  1  later-stage write enables.
- fwd_ex_addr_i, fwd_wb_addr_i  input  REG_ADDR_W  later-stage destination addresses.
- fwd_ex_data_i, fwd_wb_data_i  input  XLEN  later-stage result data.
- flush_i  input  1  discard all held and incoming operations.
- out_valid_o  output  1  alu_*_o hold a valid operation.
- out_ready_i  input  1  consumer accepts; transfer when out_valid_o && out_ready_i.
- alu_a_o, alu_b_o  output  XLEN  registered ALU operands.
- alu_op_o  output  5  registered ALU operation code.

Behaviour:
- Reset (rst_ni low, asynchronous): out_valid_o=0, all entries invalid, alu_a_o=alu_b_o=0, alu_op_o=0.
  - in_ready_o=1 from the first edge after release.
- Forwarding applies only when a source selects a register: a_sel=0 for rs1, b_sel=0 for rs2.
  - Priority is EX over WB over register-file data.
  - A forward source matches only if its we=1, its addr equals the rs addr, and the rs addr is non-zero.
  - x0 is never forwarded; rsN_data_i is used.
  - Forwarding is evaluated combinationally in the cycle of acceptance; the selected value is what gets registered.
- Storage: main entry drives the outputs; a skid entry holds one more operation. Occupancy states:
  - EMPTY: accept -> ONE.
  - ONE: accept without output transfer -> TWO (new op goes to skid). Output transfer without accept -> EMPTY. Accept and output transfer together -> ONE (new op goes to main).
  - TWO: output transfer -> ONE (skid moves to main). Accept is impossible in this state.
- in_ready_o = !(state==TWO), driven from a register only; no combinational path from out_ready_i.
- Latency: an accepted op appears on the outputs the next cycle when the block was EMPTY.
- Ordering is strict FIFO; no op is lost or duplicated.
- Outputs are stable while out_valid_o && !out_ready_i.
- When out_valid_o=0, data outputs hold their last values; consumers must ignore them.
- flush_i: next state EMPTY regardless of handshakes that cycle; an input offered in the flush cycle is discarded.
- Flush while in reset: reset dominates.

Optional Feature:
- Macro ALU_OP_CHECK_EN.
- Defined:
  - Legal alu_op_i codes are 0–8, 13, 24, 25, 28–31.
  - An accepted illegal op is dropped: it is not stored and does not change state.
  - Adds output illegal_op_o (1 bit), a sticky flag set on the cycle after such an acceptance and cleared only by reset.
- Undefined: no port, no check; every code is passed through.

Test Plan:
- Reset mid-traffic with two entries held -> out_valid_o=0 immediately, outputs 0; in_ready_o=1 after release.
- rs1_data=5, rs2_data=3, a_sel=0, b_sel=0, op=8, out_ready=1 -> next cycle out_valid=1, alu_a=5, alu_b=3, alu_op=8; the cycle after, out_valid=0.
- rs1_addr=7, fwd_ex(we=1, addr=7, data=0x11), fwd_wb(we=1, addr=7, data=0x22), rs1_data=0x33 -> alu_a=0x11.
  - Same with ex we=0 -> alu_a=0x22.
  - rs2_addr=0 with both forwards at addr 0 -> alu_b=rs2_data.
- out_ready=0, ops X, Y, Z offered back-to-back -> X and Y accepted, in_ready_o=0, Z held by decode. Then out_ready=1 -> outputs X, Y, Z in order, each exactly once.
- Two entries held and new op offered with flush_i=1 -> next cycle out_valid=0, in_ready=1, no op emitted.
- With ALU_OP_CHECK_EN: op=9 accepted -> nothing emitted, illegal_op_o=1 next cycle and stays 1. A following op=0 passes normally.
